// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, register indices
// and the ID/EX payload bundle.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 8;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [CTRL_W-1:0]     ctrl;
  } id_ex_bundle_t;

endpackage

// File: rtl/operand_bypass.sv
// One-source operand resolver: x0, then EX, MEM, WB forwarding,
// falling back to the register file.
module operand_bypass
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::XLEN
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [W-1:0]          ex_result,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [W-1:0]          mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [W-1:0]          wb_data,
  input  logic [W-1:0]          rf_rdata,
  output logic [W-1:0]          opnd
);

  logic is_zero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign is_zero = (rs == REG_ZERO);

  // A load in EX has no data yet; it is caught by the load-use stall
  assign ex_hit  = ex_valid && ex_reg_write && !ex_mem_read
                && (ex_rd == rs);
  assign mem_hit = mem_valid && mem_reg_write && (mem_rd == rs);
  assign wb_hit  = wb_reg_write && (wb_rd == rs);

  always_comb begin
    opnd = rf_rdata;
    if (is_zero)      opnd = '0;
    else if (ex_hit)  opnd = ex_result;
    else if (mem_hit) opnd = mem_result;
    else if (wb_hit)  opnd = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use
// stall, flush and a saturating stall counter.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       stall_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } occ_e;

  occ_e          occ_q, occ_d;
  id_ex_bundle_t pay_q, pay_d;
  logic [31:0]   stall_q, stall_d;

  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;
  logic            adv;
  logic            rs1_dep;
  logic            rs2_dep;
  logic            load_use;
  logic            accept;

  assign ex_valid     = (occ_q == ST_FULL);
  assign ex_rs1_val   = pay_q.rs1_val;
  assign ex_rs2_val   = pay_q.rs2_val;
  assign ex_imm       = pay_q.imm;
  assign ex_rd        = pay_q.rd;
  assign ex_reg_write = pay_q.reg_write;
  assign ex_mem_read  = pay_q.mem_read;
  assign ex_ctrl      = pay_q.ctrl;
  assign stall_count  = stall_q;

  assign adv = !ex_valid || ex_ready;

  assign rs1_dep  = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_dep  = id_rs2_used && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_mem_read
                 && (ex_rd != REG_ZERO)
                 && (rs1_dep || rs2_dep);

  assign id_ready = adv && !load_use && !flush && !rst;
  assign accept   = id_valid && id_ready;

  operand_bypass #(.W(XLEN)) u_byp_rs1 (
    .rs            (id_rs1),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_result     (ex_alu_result),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .rf_rdata      (rf_rdata1),
    .opnd          (rs1_res)
  );

  operand_bypass #(.W(XLEN)) u_byp_rs2 (
    .rs            (id_rs2),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_result     (ex_alu_result),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .rf_rdata      (rf_rdata2),
    .opnd          (rs2_res)
  );

  always_comb begin
    occ_d = occ_q;
    pay_d = pay_q;
    if (flush) begin
      occ_d = ST_EMPTY;
    end else if (accept) begin
      occ_d           = ST_FULL;
      pay_d.rs1_val   = rs1_res;
      pay_d.rs2_val   = rs2_res;
      pay_d.imm       = id_imm;
      pay_d.rd        = id_rd;
      pay_d.reg_write = id_reg_write;
      pay_d.mem_read  = id_mem_read;
      pay_d.ctrl      = id_ctrl;
    end else if (adv) begin
      occ_d = ST_EMPTY;
    end
  end

  // Flush suppresses counting even when a hazard is also present
  always_comb begin
    stall_d = stall_q;
    if (id_valid && load_use && !flush && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= ST_EMPTY;
      pay_q   <= '0;
      stall_q <= '0;
    end else begin
      occ_q   <= occ_d;
      pay_q   <= pay_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding priority,
// load-use stall, back-pressure, flush and async reset.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic        id_reg_write, id_mem_read;
  logic [31:0] id_imm;
  logic [7:0]  id_ctrl;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] ex_alu_result;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic [7:0]  ex_ctrl;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_imm        (id_imm),
    .id_ctrl       (id_ctrl),
    .rf_rdata1     (rf_rdata1),
    .rf_rdata2     (rf_rdata2),
    .ex_alu_result (ex_alu_result),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_rs1_val    (ex_rs1_val),
    .ex_rs2_val    (ex_rs2_val),
    .ex_imm        (ex_imm),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_ctrl       (ex_ctrl),
    .stall_count   (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw,
                       input logic ld);
    id_valid     = 1'b1;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = ld;
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0;
    id_reg_write = 0; id_mem_read = 0;
    id_imm = 0; id_ctrl = 0;
    rf_rdata1 = 0; rf_rdata2 = 0; ex_alu_result = 0;
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    flush = 0; ex_ready = 1;

    #2;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_rs1", ex_rs1_val, 32'd0);
    chk("rst_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("rst_idrdy", {31'd0, id_ready}, 32'd0);

    step(); step();
    rst = 1'b0;
    issue(5'd3, 1, 5'd0, 0, 5'd3, 1, 0);
    rf_rdata1 = 32'h11; id_imm = 32'h55; id_ctrl = 8'hA5;
    #1;
    chk("plain_idrdy", {31'd0, id_ready}, 32'd1);
    step();
    chk("plain_valid", {31'd0, ex_valid}, 32'd1);
    chk("plain_rs1", ex_rs1_val, 32'h11);
    chk("plain_imm", ex_imm, 32'h55);
    chk("plain_ctrl", {24'd0, ex_ctrl}, 32'hA5);
    chk("plain_rd", {27'd0, ex_rd}, 32'd3);

    // add x5 goes to EX
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    step();
    issue(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    ex_alu_result = 32'hAA; rf_rdata1 = 32'h99;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 5; mem_result = 32'hBB;
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'hCC;
    step();
    chk("fwd_ex", ex_rs1_val, 32'hAA);
    // EX now holds rd=6, so x5 resolves from MEM
    step();
    chk("fwd_mem", ex_rs1_val, 32'hBB);
    mem_valid = 0;
    step();
    chk("fwd_wb", ex_rs1_val, 32'hCC);
    wb_reg_write = 0;
    step();
    chk("fwd_rf", ex_rs1_val, 32'h99);

    // lw x7 then dependent use through rs2
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    chk("lw_load", {31'd0, ex_mem_read}, 32'd1);
    issue(5'd0, 0, 5'd7, 1, 5'd8, 1, 0);
    rf_rdata2 = 32'h4444;
    #1;
    chk("lu_idrdy", {31'd0, id_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall1", stall_count, 32'd1);
    mem_valid = 1; mem_reg_write = 1; mem_rd = 7; mem_result = 32'h1234;
    step();
    chk("lu_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_rs2", ex_rs2_val, 32'h1234);
    chk("lu_stall", stall_count, 32'd1);

    // x0 never forwarded
    mem_valid = 0;
    issue(5'd0, 1, 5'd0, 0, 5'd9, 1, 0);
    rf_rdata1 = 32'h77;
    wb_reg_write = 1; wb_rd = 0; wb_data = 32'hFFFF;
    step();
    chk("x0_rs1", ex_rs1_val, 32'd0);
    chk("x0_rd", {27'd0, ex_rd}, 32'd9);

    // back-pressure: outputs frozen, bypass inputs churn
    ex_ready = 0;
    issue(5'd5, 1, 5'd6, 1, 5'd10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      wb_rd = 5'd5; wb_data = 32'h100 + i;
      mem_valid = 1; mem_rd = 5'd6; mem_result = 32'h200 + i;
      #1;
      chk("bp_idrdy", {31'd0, id_ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, ex_valid}, 32'd1);
      chk("bp_rs1", ex_rs1_val, 32'd0);
      chk("bp_rd", {27'd0, ex_rd}, 32'd9);
    end
    flush = 1;
    step();
    chk("fl_bp_valid", {31'd0, ex_valid}, 32'd0);

    // flush beats load-use and does not count
    flush = 0; ex_ready = 1;
    mem_valid = 0; wb_reg_write = 0;
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    issue(5'd7, 1, 5'd0, 0, 5'd11, 1, 0);
    flush = 1;
    step();
    chk("fl_lu_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_lu_stall", stall_count, 32'd1);

    // build stall_count up to 5 under back-pressure
    flush = 0;
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    ex_ready = 0;
    issue(5'd7, 1, 5'd0, 0, 5'd12, 1, 0);
    repeat (4) step();
    chk("pre_rst_stall", stall_count, 32'd5);
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_stall", stall_count, 32'd0);
    chk("arst_rd", {27'd0, ex_rd}, 32'd0);
    chk("arst_idrdy", {31'd0, id_ready}, 32'd0);
    step();
    rst = 1'b0;
    id_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register for the 5-stage CPU core. Sits directly downstream of `register_file`: takes the combinational `read_data1`/`read_data2` for the instruction in decode, resolves them against in-flight results (EX, MEM, WB bypass), detects load-use hazards, and presents a registered, fully resolved operand bundle to the EX stage. It uses a valid/ready handshake with stall, bubble insertion and flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CTRL_W`, 8, width of the opaque decoded control bundle that passes through.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_ready` out 1: stage accepts the decode instruction this cycle (combinational).
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices.
- `id_rs1_used`, `id_rs2_used` in 1: the instruction actually reads rs1/rs2.
- `id_reg_write`, `id_mem_read` in 1: writes rd / is a load.
- `id_imm` in XLEN; `id_ctrl` in CTRL_W: pass-through.
- `rf_rdata1`, `rf_rdata2` in XLEN: from the register file read ports.
- `ex_alu_result` in XLEN: combinational EX result of the instruction currently on this block's outputs.
- `mem_valid`, `mem_reg_write` in 1; `mem_rd` in 5; `mem_result` in XLEN: MEM-stage instruction. `mem_result` is final, including load data.
- `wb_reg_write` in 1; `wb_rd` in 5; `wb_data` in XLEN: the same signals driving the register-file write port.
- `flush` in 1: branch/redirect kill from EX.
- `ex_ready` in 1: EX accepts the current output.
- `ex_valid` out 1; `ex_rs1_val`, `ex_rs2_val`, `ex_imm` out XLEN; `ex_rd` out 5; `ex_reg_write`, `ex_mem_read` out 1; `ex_ctrl` out CTRL_W.
- `stall_count` out 32: saturating count of load-use stall cycles.

## Operation
- Occupancy is a single FULL/EMPTY state, equal to `ex_valid`.
- Advance condition: `adv = !ex_valid || ex_ready`.
- Load-use hazard: `ex_valid && ex_mem_read && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd))`.
- `id_ready = adv && !load_use && !flush`.
- Operand resolution per source (rsN), first match wins:
  - rsN == 0 gives 0.
  - EX match (`ex_valid && ex_reg_write && !ex_mem_read && ex_rd == rsN`) gives `ex_alu_result`.
  - MEM match (`mem_valid && mem_reg_write && mem_rd == rsN`) gives `mem_result`.
  - WB match (`wb_reg_write && wb_rd == rsN`) gives `wb_data`.
  - Otherwise `rf_rdataN`.
  - Match requires rsN != 0.
- Register update at each posedge, in priority order:
  - `flush` → `ex_valid <= 0`; the decode instruction is not accepted.
  - `id_valid && id_ready` → capture the resolved operands and all pass-through fields; `ex_valid <= 1`.
  - `adv && !(id_valid && id_ready)` → `ex_valid <= 0` (bubble, including the load-use bubble).
  - Otherwise hold every output.
- Payload registers are not required to clear on a bubble; only `ex_valid` is meaningful.
- `stall_count` increments on each cycle with `id_valid && load_use && !flush` and saturates at 0xFFFF_FFFF.

## Timing
- Reset: `ex_valid = 0`, all payload outputs 0, `stall_count = 0`.
- `id_ready` is low while `rst` is asserted.
- Latency: an instruction accepted at edge N appears on the outputs after edge N.
- Load-use costs exactly one bubble when `ex_ready = 1`. On the following cycle the load is in MEM and the dependent instruction resolves from `mem_result`.
- Back-pressure (`ex_valid && !ex_ready`): the outputs hold bit-stable and `id_ready = 0`. Operands already captured are not re-resolved.
- `flush` together with `ex_ready = 0`: the output is still killed.
- `flush` together with a load-use hazard: flush wins and the stall is not counted.
- Reset asserted mid-operation clears the outputs immediately (asynchronously). The decode instruction is dropped.
- WB bypass is required because the register file writes on the same edge; a same-cycle read returns the old value.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN`
  - `REG_ADDR_W = 5`
  - `REG_ZERO = 5'd0`
  - `CTRL_W`
  - Packed typedef `id_ex_bundle_t` (operands, imm, rd, reg_write, mem_read, ctrl).
- One sub-module, `operand_bypass`: combinational 5-way select with priority as above. It is instantiated twice (rs1, rs2). The top level holds the register, handshake, hazard logic and counter.

## Test plan
- Reset, then issue `id_rs1 = 3` with `rf_rdata1 = 0x11`, no bypass → one cycle later `ex_valid = 1`, `ex_rs1_val = 0x11`.
- EX output holds `add x5` (reg_write, not load) with `ex_alu_result = 0xAA`; `mem_rd = 5` with `mem_result = 0xBB`; `wb_rd = 5` with `wb_data = 0xCC`; ID reads x5 → `ex_rs1_val = 0xAA`. Remove the EX match → 0xBB. Remove the MEM match → 0xCC.
- EX output holds `lw x7`; ID uses rs2 = 7 with `ex_ready = 1` → `id_ready = 0`, next cycle `ex_valid = 0`, `stall_count = 1`. Then `mem_result = 0x1234` → the instruction is captured with `ex_rs2_val = 0x1234`.
- `id_rs1 = 0` while `wb_rd = 0`, `wb_reg_write = 1`, `wb_data = 0xFFFF` → `ex_rs1_val = 0`.
- `ex_valid = 1`, `ex_ready = 0` for 3 cycles while the bypass inputs change → outputs unchanged, `id_ready = 0`. Assert `flush` → `ex_valid = 0` next edge.
- Assert `rst` mid-stream with `ex_valid = 1` and `stall_count = 5` → `ex_valid = 0` and `stall_count = 0` before the next clock edge.
